alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, handshaked successor to the combinational ALU in the execute stage. It is parametrised in width and registers its result. Single-cycle ops return one cycle after acceptance. Unsigned DIV/REM run on an iterative restoring divider, and divide-by-zero plus illegal opcodes produce defined results and an error flag instead of X. Valid/ready on both sides lets the pipeline stall the execute stage around long divisions.

## Interface
- DATA_WIDTH, default 32: operand/result width in bits, >= 2.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  block accepts a request this cycle.
- i_op  in  alu_op_e  operation (ADD, SUB, AND, OR, XOR, MUL, DIV, REM).
- i_elemA  in  DATA_WIDTH  operand A (dividend).
- i_elemB  in  DATA_WIDTH  operand B (divisor).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_output  out  DATA_WIDTH  result.
- o_zero  out  1  o_output == 0.
- o_err  out  1  divide-by-zero or illegal opcode.

## Operation
- Accept: i_valid && o_ready at a rising edge. Operands and op are captured; later input changes are ignored.
- o_ready = !i_rst && state==IDLE && (!o_valid || i_ready). This combinational path allows back-to-back single-cycle ops.
- FSM states: IDLE, DIV_BUSY.
  - IDLE: accept of a single-cycle op loads the result register and stays in IDLE. Accept of DIV/REM with B!=0 goes to DIV_BUSY.
  - DIV_BUSY: one quotient bit per cycle, MSB first, DATA_WIDTH cycles. On the last iteration the result register is loaded and the FSM returns to IDLE. No accept in this state.
- Arithmetic, all unsigned, wrap modulo 2^DATA_WIDTH:
  - ADD, SUB, AND, OR, XOR: as named.
  - MUL: low DATA_WIDTH bits of the product.
  - DIV: quotient. REM: remainder.
- Divide by zero: DIV returns all ones, REM returns A, o_err=1. Completes in single-cycle latency with no iteration.
- Illegal/undefined op encoding: o_output=0, o_err=1, single-cycle latency.
- o_zero and o_err are registered together with o_output.
- Output hold: while o_valid && !i_ready, o_output/o_zero/o_err are stable. o_valid clears on the handshake unless a new result loads the same edge.

## Timing
- Reset values:
  - o_valid=0, o_output=0, o_zero=0, o_err=0, state=IDLE.
  - o_ready=0 while i_rst is high and 1 on the first cycle after.
- Latency, accept edge to o_valid high:
  - single-cycle ops and div-by-zero: 1 cycle.
  - DIV/REM with B!=0: DATA_WIDTH+1 cycles.
- Throughput: 1 per cycle for single-cycle ops when i_ready stays high. Divider requests are not overlapped.
- Divider start with o_valid high: a DIV accepted while the previous result is being consumed (o_valid && i_ready) starts iterating immediately.
- Divider completion under backpressure: if a divide finishes while the previous result is still unconsumed, the FSM stays in DIV_BUSY on its final iteration until o_valid clears. This cannot happen given the o_ready rule, but the bench asserts it.
- Reset mid-division: the FSM aborts to IDLE, partial state is discarded and o_valid=0 next cycle.

## Configuration
- ALU_MC_DIV_EN defined: divider sub-module and DIV_BUSY state are compiled in, behaving as above.
- ALU_MC_DIV_EN undefined:
  - no divider logic; DIV/REM behave as illegal ops (o_output=0, o_err=1, 1-cycle latency).
  - the FSM never leaves IDLE.

## Structure
- alu_pkg holds:
  - alu_op_e, extended with REM; existing encodings unchanged.
  - alu_mc_state_e {IDLE, DIV_BUSY}.
  - function alu_is_div(alu_op_e).
- One sub-module, alu_div_iter: restoring divider.
  - parameter DATA_WIDTH.
  - inputs start, dividend, divisor.
  - outputs done, quotient, remainder, with an internal bit counter of $clog2(DATA_WIDTH)+1 bits.
  - Instantiated only under ALU_MC_DIV_EN.
- alu_mc holds the handshake, FSM, single-cycle datapath and result register.

## Test plan
- DATA_WIDTH=32, back-to-back:
  - stimulus: ADD 5+7, then SUB 3-5, then XOR 0xFF00FF00^0x0F0F0F0F, with i_ready=1.
  - response: o_valid on 3 consecutive cycles, results 12, 0xFFFFFFFE, 0xF00FF00F.
  - o_zero=0 and o_err=0 on all three.
- DIV 100/7 (DATA_WIDTH=32):
  - o_ready low for 32 cycles.
  - o_output=14 at cycle 33 after accept.
  - Follow-up REM 100/7 returns 2.
- Divide by zero: DIV 9/0 gives 0xFFFFFFFF with o_err=1 after 1 cycle; REM 9/0 gives 9 with o_err=1.
- Backpressure:
  - stimulus: MUL 0x10000*0x10000 with i_ready=0 for 4 cycles.
  - response: o_output=0 and o_zero=1, held stable.
  - o_ready stays 0 until i_ready rises.
- Reset mid-operation: assert i_rst 10 cycles into DIV 1000/3. Next cycle o_valid=0, state IDLE, o_ready=1 one cycle after reset release.
- Build without ALU_MC_DIV_EN: DIV 10/2 gives o_output=0 and o_err=1 with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the multi-cycle ALU.
//   alu_op_e        4-bit opcode; encodings 8..15 are illegal
//   alu_mc_state_e  control FSM states of alu_mc
//   alu_is_div()    true for the ops that use the iterative divider
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MUL = 4'd5,
    OP_DIV = 4'd6,
    OP_REM = 4'd7
  } alu_op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } alu_mc_state_e;

  // Ops that need the iterative divider (when it is built in).
  function automatic logic alu_is_div(alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: unsigned restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst          clock and synchronous active-high reset
//   start             load dividend/divisor and begin DATA_WIDTH iterations
//   hold              freeze on the final iteration (result not yet takeable)
//   dividend, divisor operands, sampled only on start (divisor must be nonzero)
//   done              final iteration is being performed this cycle
//   quotient          quotient after the current iteration (valid when done)
//   remainder         remainder after the current iteration (valid when done)
module alu_div_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0]      cnt_q;   // iterations still to run; 0 = idle

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] rem_n;
  logic [DATA_WIDTH-1:0] quo_n;

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[DATA_WIDTH]) begin
      rem_n = shifted[DATA_WIDTH-1:0];
      quo_n = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_n = diff[DATA_WIDTH-1:0];
      quo_n = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end
  end

  assign done      = (cnt_q == CNT_W'(1));
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(DATA_WIDTH);
    end else if ((cnt_q != '0) && !(done && hold)) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU with registered result.
//   Optional divider: define ALU_MC_DIV_EN to build DIV/REM support; without
//   it DIV/REM are treated as illegal ops and the FSM stays in IDLE.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid/o_ready   request handshake; i_op, i_elemA, i_elemB captured on accept
//   o_valid/i_ready   result handshake; o_output, o_zero, o_err held until taken
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  alu_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_elemA,
  input  logic [DATA_WIDTH-1:0] i_elemB,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_output,
  output logic                  o_zero,
  output logic                  o_err
);

  alu_mc_state_e         state;
  logic                  out_free;   // result register may be (re)loaded this edge
  logic                  accept;
  logic [DATA_WIDTH-1:0] sc_result;
  logic                  sc_err;
  logic                  div_req;    // accepted op must go to the divider

  assign out_free = !o_valid || i_ready;
  assign o_ready  = !i_rst && (state == IDLE) && out_free;
  assign accept   = i_valid && o_ready;

  // Single-cycle datapath, including divide-by-zero and illegal-op results.
  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    div_req   = 1'b0;
    case (i_op)
      OP_ADD: sc_result = i_elemA + i_elemB;
      OP_SUB: sc_result = i_elemA - i_elemB;
      OP_AND: sc_result = i_elemA & i_elemB;
      OP_OR:  sc_result = i_elemA | i_elemB;
      OP_XOR: sc_result = i_elemA ^ i_elemB;
      OP_MUL: sc_result = i_elemA * i_elemB;
`ifdef ALU_MC_DIV_EN
      OP_DIV, OP_REM: begin
        if (i_elemB == '0) begin
          sc_result = (i_op == OP_DIV) ? '1 : i_elemA;
          sc_err    = 1'b1;
        end else begin
          div_req = alu_is_div(i_op);
        end
      end
`endif
      default: begin
        sc_result = '0;
        sc_err    = 1'b1;
      end
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic                  div_done;
  logic                  is_rem;
  logic [DATA_WIDTH-1:0] div_quo;
  logic [DATA_WIDTH-1:0] div_rem;
  logic [DATA_WIDTH-1:0] div_result;

  alu_div_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (accept && div_req),
    .hold      (!out_free),
    .dividend  (i_elemA),
    .divisor   (i_elemB),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_result = is_rem ? div_rem : div_quo;
`endif

  // Control FSM and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_output <= '0;
      o_zero   <= 1'b0;
      o_err    <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_rem   <= 1'b0;
`endif
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_req) begin
              state <= DIV_BUSY;
`ifdef ALU_MC_DIV_EN
              is_rem <= (i_op == OP_REM);
`endif
            end else begin
              o_valid  <= 1'b1;
              o_output <= sc_result;
              o_zero   <= (sc_result == '0);
              o_err    <= sc_err;
            end
          end
        end
`ifdef ALU_MC_DIV_EN
        // Final iteration loads the result; stalls here if the old one is unconsumed.
        DIV_BUSY: begin
          if (div_done && out_free) begin
            state    <= IDLE;
            o_valid  <= 1'b1;
            o_output <= div_result;
            o_zero   <= (div_result == '0);
            o_err    <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (DATA_WIDTH=32).
//   Divider scenarios follow ALU_MC_DIV_EN; without it DIV/REM must act as illegal ops.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         i_clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  alu_op_e      i_op;
  logic [W-1:0] i_elemA;
  logic [W-1:0] i_elemB;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_output;
  logic         o_zero;
  logic         o_err;

  int checks = 0;
  int errors = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_elemA  (i_elemA),
    .i_elemB  (i_elemB),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_output (o_output),
    .o_zero   (o_zero),
    .o_err    (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // A divide must never be in flight while an unconsumed result is pending.
  always @(negedge i_clk) begin
    if (!i_rst && dut.state == DIV_BUSY) begin
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL div_busy_valid: o_valid=%b during DIV_BUSY, required 0", o_valid);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_valid = 1'b1;
    i_op    = op;
    i_elemA = a;
    i_elemB = b;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    i_op    = OP_ADD;
    i_elemA = '0;
    i_elemB = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle_inputs();
    i_ready = 1'b1;
    step();
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", o_valid); end
    checks++; if (o_output !== 32'h0) begin errors++; $display("FAIL rst_output: got %h required 00000000", o_output); end
    checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b required 0", o_zero); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", o_err); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b required 0", o_ready); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d required IDLE", dut.state); end
    i_rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b required 1", o_ready); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp [3];
    exp[0] = 32'd12;
    exp[1] = 32'hFFFF_FFFE;
    exp[2] = 32'hF00F_F00F;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(OP_ADD, 32'd5, 32'd7);
        1: drive(OP_SUB, 32'd3, 32'd5);
        default: drive(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
      endcase
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b required 1", k, o_ready); end
      step();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b required 1", k, o_valid); end
      checks++; if (o_output !== exp[k]) begin errors++; $display("FAIL b2b_output[%0d]: got %h required %h", k, o_output, exp[k]); end
      checks++; if (o_zero !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL b2b_flags[%0d]: zero=%b err=%b required 0 0", k, o_zero, o_err); end
    end
    idle_inputs();
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: o_valid got %b required 0", o_valid); end
  endtask

  task automatic test_illegal();
    i_ready = 1'b1;
    drive(alu_op_e'(4'hF), 32'd5, 32'd3);
    step();
    idle_inputs();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b required 1", o_valid); end
    checks++; if (o_output !== 32'h0) begin errors++; $display("FAIL illegal_output: got %h required 00000000", o_output); end
    checks++; if (o_err !== 1'b1 || o_zero !== 1'b1) begin errors++; $display("FAIL illegal_flags: err=%b zero=%b required 1 1", o_err, o_zero); end
    step();
  endtask

  task automatic test_div_zero();
    logic [W-1:0] exp_div;
    logic [W-1:0] exp_rem;
`ifdef ALU_MC_DIV_EN
    exp_div = 32'hFFFF_FFFF;
    exp_rem = 32'd9;
`else
    exp_div = 32'h0;
    exp_rem = 32'h0;
`endif
    i_ready = 1'b1;
    drive(OP_DIV, 32'd9, 32'd0);
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL dz_div_valid: got %b required 1", o_valid); end
    checks++; if (o_output !== exp_div) begin errors++; $display("FAIL dz_div_output: got %h required %h", o_output, exp_div); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL dz_div_err: got %b required 1", o_err); end
    drive(OP_REM, 32'd9, 32'd0);
    step();
    idle_inputs();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL dz_rem_valid: got %b required 1", o_valid); end
    checks++; if (o_output !== exp_rem) begin errors++; $display("FAIL dz_rem_output: got %h required %h", o_output, exp_rem); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL dz_rem_err: got %b required 1", o_err); end
    step();
  endtask

`ifdef ALU_MC_DIV_EN
  // Waits for a divide accepted on the previous step; returns latency and busy cycles.
  task automatic wait_div(output int lat, output int busy);
    lat  = 1;
    busy = 0;
    while (!o_valid && lat < 100) begin
      if (!o_ready) busy++;
      step();
      lat++;
    end
  endtask

  task automatic test_div();
    int lat;
    int busy;
    i_ready = 1'b1;
    drive(OP_DIV, 32'd100, 32'd7);
    step();
    drive(OP_ADD, 32'd1, 32'd1);   // ignored while busy
    i_valid = 1'b0;
    wait_div(lat, busy);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d required 33", lat); end
    checks++; if (busy != 32) begin errors++; $display("FAIL div_ready_low: got %0d cycles required 32", busy); end
    checks++; if (o_output !== 32'd14) begin errors++; $display("FAIL div_output: got %h required %h", o_output, 32'd14); end
    checks++; if (o_err !== 1'b0 || o_zero !== 1'b0) begin errors++; $display("FAIL div_flags: err=%b zero=%b required 0 0", o_err, o_zero); end
    // REM accepted on the same edge the DIV result is consumed.
    drive(OP_REM, 32'd100, 32'd7);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rem_ready: got %b required 1", o_ready); end
    step();
    idle_inputs();
    wait_div(lat, busy);
    checks++; if (lat != 33) begin errors++; $display("FAIL rem_latency: got %0d required 33", lat); end
    checks++; if (o_output !== 32'd2) begin errors++; $display("FAIL rem_output: got %h required %h", o_output, 32'd2); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int busy;
    i_ready = 1'b1;
    drive(OP_DIV, 32'd1000, 32'd3);
    step();
    idle_inputs();
    repeat (10) step();
    i_rst = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", o_valid); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d required IDLE", dut.state); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b required 0", o_ready); end
    i_rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b required 1", o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %b required 0", o_valid); end
    drive(OP_DIV, 32'd1000, 32'd3);
    step();
    idle_inputs();
    wait_div(lat, busy);
    checks++; if (lat != 33) begin errors++; $display("FAIL rmid_rerun_latency: got %0d required 33", lat); end
    checks++; if (o_output !== 32'd333) begin errors++; $display("FAIL rmid_rerun_output: got %h required %h", o_output, 32'd333); end
    step();
  endtask
`else
  task automatic test_no_div();
    i_ready = 1'b1;
    drive(OP_DIV, 32'd10, 32'd2);
    step();
    idle_inputs();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL nodiv_valid: got %b required 1", o_valid); end
    checks++; if (o_output !== 32'h0) begin errors++; $display("FAIL nodiv_output: got %h required 00000000", o_output); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL nodiv_err: got %b required 1", o_err); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL nodiv_state: got %0d required IDLE", dut.state); end
    step();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    drive(OP_MUL, 32'd3, 32'd4);
    step();
    idle_inputs();
    step();
    i_rst = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b required 0", o_ready); end
    i_rst = 1'b0;
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b required 1", o_ready); end
    step();
  endtask
`endif

  task automatic test_backpressure();
    i_ready = 1'b0;
    drive(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    step();
    drive(OP_ADD, 32'd1, 32'd1);   // must not be taken while stalled
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", k, o_valid); end
      checks++; if (o_output !== 32'h0 || o_zero !== 1'b1 || o_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: out=%h zero=%b err=%b required 00000000 1 0", k, o_output, o_zero, o_err); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b required 0", k, o_ready); end
      if (k < 3) step();
    end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", o_ready); end
    step();
    idle_inputs();
    checks++; if (o_valid !== 1'b1 || o_output !== 32'd2) begin errors++; $display("FAIL bp_next: valid=%b out=%h required 1 00000002", o_valid, o_output); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b required 0", o_valid); end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_illegal();
    test_div_zero();
`ifdef ALU_MC_DIV_EN
    test_div();
`else
    test_no_div();
`endif
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
